// File: rtl/uart_axil_pkg.sv
// Shared constants for the UART AXI4-Lite responder: register offsets, register
// bit positions and AXI response codes.
package uart_axil_pkg;

  // Register byte offsets within the 32-byte window
  localparam logic [4:0] OFS_RBR = 5'h00;  // RBR on read, THR on write
  localparam logic [4:0] OFS_IER = 5'h04;
  localparam logic [4:0] OFS_IIR = 5'h08;
  localparam logic [4:0] OFS_MCR = 5'h10;
  localparam logic [4:0] OFS_LSR = 5'h14;

  // LSR bits
  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_OE   = 1;
  localparam int unsigned LSR_THRE = 5;
  localparam int unsigned LSR_TEMT = 6;

  // IER bits
  localparam int unsigned IER_ERBFI = 0;
  localparam int unsigned IER_ETBEI = 1;

  // MCR loopback bit
  localparam int unsigned MCR_LOOP = 4;

  // IIR encodings, highest priority first
  localparam logic [7:0] IIR_RX   = 8'h04;
  localparam logic [7:0] IIR_TX   = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word-aligned register offset; the byte lane bits are ignored
  function automatic logic [4:0] reg_ofs(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_axil_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module uart_axil_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next state; pointers wrap naturally at Depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since occupancy guards every read
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_axil_responder.sv
// AXI4-Lite responder exposing a 16550-subset UART register file. TX bytes are
// streamed out to a serializer, RX bytes come in from a deserializer.
// Optional feature: define UART_AXIL_LOOPBACK_EN to enable MCR[4] loopback.
module uart_axil_responder
  import uart_axil_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              chipset_clk,
  input  logic              chipset_rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              uart_irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic              rdy_q, rdy_d;
  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_strb0_q, w_strb0_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [1:0]        ier_q, ier_d;
  logic              oe_q, oe_d;
  logic              irq_q, irq_d;
`ifdef UART_AXIL_LOOPBACK_EN
  logic              mcr_loop_q, mcr_loop_d;
`endif

  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]      tx_head;
  logic [CntW-1:0] tx_count;
  logic            rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]      rx_head, rx_wdata;
  logic [CntW-1:0] rx_count;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        wr_exec, wr_bad, wr_en;
  logic [4:0]  wr_ofs, rd_ofs;
  logic        rd_bad, lsr_rd, rx_overrun;
  logic        dr, thre, rx_irq, tx_irq;
  logic [7:0]  lsr, iir;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign unused_bits = ^{s_wdata[31:8], s_wstrb[3:1], s_araddr[1:0], aw_addr_q[1:0], tx_full};

  assign rdy_d     = 1'b1;
  assign s_awready = rdy_q & ~aw_full_q;
  assign s_wready  = rdy_q & ~w_full_q;
  assign s_arready = rdy_q & ~rvalid_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign uart_irq  = irq_q;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = bvalid_q & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = rvalid_q & s_rready;

  // Write executes once both halves are held and no response is outstanding
  assign wr_exec = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_ofs  = reg_ofs(aw_addr_q[4:0]);
  assign wr_bad  = |aw_addr_q[ADDR_W-1:5];
  assign wr_en   = wr_exec & ~wr_bad & w_strb0_q;
  assign tx_push = wr_en & (wr_ofs == OFS_RBR);

  assign rd_ofs = reg_ofs(s_araddr[4:0]);
  assign rd_bad = |s_araddr[ADDR_W-1:5];
  assign rx_pop = ar_hs & ~rd_bad & (rd_ofs == OFS_RBR) & ~rx_empty;
  assign lsr_rd = ar_hs & ~rd_bad & (rd_ofs == OFS_LSR);

  assign dr     = (rx_count != '0);
  assign thre   = (tx_count == '0);
  assign rx_irq = ier_q[IER_ERBFI] & dr;
  assign tx_irq = ier_q[IER_ETBEI] & thre;
  assign iir    = rx_irq ? IIR_RX : (tx_irq ? IIR_TX : IIR_NONE);

  assign tx_data = tx_head;

`ifdef UART_AXIL_LOOPBACK_EN
  // Loopback steals the TX stream for the RX FIFO and silences the serializer
  assign tx_valid = ~mcr_loop_q & ~tx_empty;
  assign tx_pop   = mcr_loop_q ? (~tx_empty & ~rx_full) : (tx_valid & tx_ready);
  assign rx_push  = mcr_loop_q ? tx_pop : rx_valid;
  assign rx_wdata = mcr_loop_q ? tx_head : rx_data;
`else
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid;
  assign rx_wdata = rx_data;
`endif

  // A simultaneous RBR pop makes room, so only a push with no pop can overrun
  assign rx_overrun = rx_push & rx_full & ~rx_pop;

  // Line status word
  always_comb begin
    lsr           = '0;
    lsr[LSR_DR]   = dr;
    lsr[LSR_OE]   = oe_q;
    lsr[LSR_THRE] = thre;
    lsr[LSR_TEMT] = thre & ~tx_valid;
  end

  // Read data mux, sampled on the AR handshake
  always_comb begin
    rd_word = '0;
    case (rd_ofs)
      OFS_RBR: rd_word = rx_empty ? 32'h0 : {24'h0, rx_head};
      OFS_IER: rd_word = {30'h0, ier_q};
      OFS_IIR: rd_word = {24'h0, iir};
`ifdef UART_AXIL_LOOPBACK_EN
      OFS_MCR: rd_word[MCR_LOOP] = mcr_loop_q;
`endif
      OFS_LSR: rd_word = {24'h0, lsr};
      default: rd_word = '0;
    endcase
    if (rd_bad) rd_word = '0;
  end

  // Channel, register and interrupt next state
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb0_d = w_strb0_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ier_d     = ier_q;
    oe_d      = oe_q;
`ifdef UART_AXIL_LOOPBACK_EN
    mcr_loop_d = mcr_loop_q;
`endif

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (w_hs) begin
      w_full_d  = 1'b1;
      w_data_d  = s_wdata[7:0];
      w_strb0_d = s_wstrb[0];
    end
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
    if (wr_exec) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_bad ? RESP_SLVERR : RESP_OKAY;
    end
    if (wr_en && (wr_ofs == OFS_IER)) ier_d = w_data_q[1:0];
`ifdef UART_AXIL_LOOPBACK_EN
    if (wr_en && (wr_ofs == OFS_MCR)) mcr_loop_d = w_data_q[MCR_LOOP];
`endif

    if (r_hs) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_bad ? RESP_SLVERR : RESP_OKAY;
    end

    // A fresh overrun wins over the clear-on-read
    if (lsr_rd)     oe_d = 1'b0;
    if (rx_overrun) oe_d = 1'b1;

    irq_d = rx_irq | tx_irq;
  end

  // State registers
  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb0_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ier_q     <= '0;
      oe_q      <= 1'b0;
      irq_q     <= 1'b0;
`ifdef UART_AXIL_LOOPBACK_EN
      mcr_loop_q <= 1'b0;
`endif
    end else begin
      rdy_q     <= rdy_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb0_q <= w_strb0_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ier_q     <= ier_d;
      oe_q      <= oe_d;
      irq_q     <= irq_d;
`ifdef UART_AXIL_LOOPBACK_EN
      mcr_loop_q <= mcr_loop_d;
`endif
    end
  end

  uart_axil_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_tx_fifo (
    .clk_i   (chipset_clk),
    .rst_i   (chipset_rst),
    .push_i  (tx_push),
    .data_i  (w_data_q),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  uart_axil_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_rx_fifo (
    .clk_i   (chipset_clk),
    .rst_i   (chipset_rst),
    .push_i  (rx_push),
    .data_i  (rx_wdata),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

endmodule
